// File: rtl/axil_uart_write_master_if.sv
// AXI4-Lite write-channel bundle (AW/W/B) between the UART write master and the memory slave.
interface axil_uart_write_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
        input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, M_AXI_BREADY,
        output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
    );
endinterface

// File: rtl/axil_uart_write_master.sv
// Buffers 16-bit UART words in a small FIFO and writes each one to an AXI4-Lite slave as a
// half-word (duplicated on both lanes, strobed by address bit 1), tracking count and errors.
module axil_uart_write_master #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned WORD_WIDTH         = 16,
    parameter int unsigned FIFO_DEPTH         = 4
) (
    input  logic                          M_AXI_ACLK,
    input  logic                          M_AXI_ARESETN,
    input  logic [WORD_WIDTH-1:0]         word_data,
    input  logic                          word_valid,
    output logic                          word_ready,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] start_addr,
    input  logic                          load_addr,
    input  logic                          clear_error,
    axil_uart_write_master_if.master      m_axi,
    output logic                          busy,
    output logic [15:0]                   words_written,
    output logic                          write_error,
    output logic                          Interrupt
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_ONE = {{(C_M_AXI_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0] ADDR_TWO = ADDR_ONE << 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ADDR_DATA = 2'd1;
    localparam logic [1:0] ST_RESP      = 2'd2;

    generate
        if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
            $error("axil_uart_write_master: C_M_AXI_DATA_WIDTH must be 32");
        end
        if (2 * WORD_WIDTH != C_M_AXI_DATA_WIDTH) begin : g_bad_word_width
            $error("axil_uart_write_master: WORD_WIDTH must be half the data width");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("axil_uart_write_master: FIFO_DEPTH must be a power of 2 and >= 2");
        end
    endgenerate

    logic [WORD_WIDTH-1:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W:0]                r_wr_ptr;
    logic [PTR_W:0]                r_rd_ptr;
    logic [1:0]                    r_state;
    logic [WORD_WIDTH-1:0]         r_word;
    logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
    logic                          r_awvalid;
    logic                          r_wvalid;
    logic                          r_bready;
    logic [15:0]                   r_words;
    logic                          r_write_error;
    logic                          r_interrupt;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_aw_done;
    logic w_w_done;
    logic w_b_hs;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                       (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
    assign w_push    = word_valid && !w_full;
    assign w_pop     = (r_state == ST_IDLE) && !w_empty;
    assign w_aw_done = !r_awvalid || m_axi.M_AXI_AWREADY;
    assign w_w_done  = !r_wvalid || m_axi.M_AXI_WREADY;
    assign w_b_hs    = r_bready && m_axi.M_AXI_BVALID;

    always_ff @(posedge M_AXI_ACLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= word_data;
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_state       <= ST_IDLE;
            r_word        <= '0;
            r_addr        <= '0;
            r_awvalid     <= 1'b0;
            r_wvalid      <= 1'b0;
            r_bready      <= 1'b0;
            r_words       <= '0;
            r_write_error <= 1'b0;
            r_interrupt   <= 1'b0;
        end else begin
            r_interrupt <= 1'b0;
            // A new error later in this block overrides the clear.
            if (clear_error) begin
                r_write_error <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (load_addr) begin
                        r_addr  <= start_addr & ~ADDR_ONE;
                        r_words <= '0;
                    end
                    if (w_pop) begin
                        r_word    <= r_mem[r_rd_ptr[PTR_W-1:0]];
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= ST_ADDR_DATA;
                    end
                end
                ST_ADDR_DATA: begin
                    if (m_axi.M_AXI_AWREADY) begin
                        r_awvalid <= 1'b0;
                    end
                    if (m_axi.M_AXI_WREADY) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        r_words  <= r_words + 16'd1;
                        r_addr   <= r_addr + ADDR_TWO;
                        r_state  <= ST_IDLE;
                        if (m_axi.M_AXI_BRESP != 2'b00) begin
                            r_write_error <= 1'b1;
                            r_interrupt   <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_axi.M_AXI_AWADDR  = {r_addr[C_M_AXI_ADDR_WIDTH-1:2], 2'b00};
    assign m_axi.M_AXI_AWVALID = r_awvalid;
    assign m_axi.M_AXI_WDATA   = {r_word, r_word};
    // Gated so the strobe reads zero whenever no write data is offered.
    assign m_axi.M_AXI_WSTRB   = !r_wvalid ? 4'b0000 : (r_addr[1] ? 4'b1100 : 4'b0011);
    assign m_axi.M_AXI_WVALID  = r_wvalid;
    assign m_axi.M_AXI_BREADY  = r_bready;

    assign word_ready    = !w_full;
    assign busy          = (r_state != ST_IDLE) || !w_empty;
    assign words_written = r_words;
    assign write_error   = r_write_error;
    assign Interrupt     = r_interrupt;
endmodule
